// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester streams and the uart-side pulse interface.
// master = requesters plus uart ready source; slave = the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQUESTERS = 2,
   parameter int DATA_WIDTH     = 8
);
   logic [NUM_REQUESTERS-1:0]            req_axiiv;
   logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_axiid;
   logic [NUM_REQUESTERS-1:0]            req_axilast;
   logic [NUM_REQUESTERS-1:0]            req_axiready;
   logic [NUM_REQUESTERS-1:0]            grant;
   logic                                 busy;
   logic                                 uart_axiiv;
   logic [DATA_WIDTH-1:0]                uart_axiid;
   logic                                 uart_axiready;

   modport master (
      output req_axiiv, req_axiid, req_axilast, uart_axiready,
      input  req_axiready, grant, busy, uart_axiiv, uart_axiid
   );

   modport slave (
      input  req_axiiv, req_axiid, req_axilast, uart_axiready,
      output req_axiready, grant, busy, uart_axiiv, uart_axiid
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart transmitter between requesters.
// Handshake: a requester byte moves when req_axiiv & req_axiready; the uart sees a one-cycle uart_axiiv pulse.
module uart_tx_arbiter #(
   parameter int NUM_REQUESTERS = 2,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_arbiter_if.slave    bus,
   output logic                state_o
);
   localparam int PW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                    state_q, state_d;
   logic [PW-1:0]             ptr_q, ptr_d;
   logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
   logic                      busy_q, busy_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      uv_q, uv_d;
   logic [DATA_WIDTH-1:0]     ud_q, ud_d;

   logic [NUM_REQUESTERS-1:0] ready;
   logic                      accept;
   logic                      last_g;
   logic [DATA_WIDTH-1:0]     byte_g;
   logic                      found;
   logic [PW-1:0]             winner;
   int                        idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NUM_REQUESTERS - 1);
         grant_q <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         uv_q    <= 1'b0;
         ud_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         uv_q    <= uv_d;
         ud_q    <= ud_d;
      end
   end

   // The ~uv_q term leaves a gap cycle because uart_axiready may lag an accept by one cycle.
   always_comb begin
      ready = '0;
      if (state_q == LOCKED) ready[ptr_q] = bus.uart_axiready & ~uv_q;
      accept = |(bus.req_axiiv & ready);
      last_g = bus.req_axilast[ptr_q];
      byte_g = bus.req_axiid[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan starts just after the last owner so the previous winner has the lowest priority.
   always_comb begin
      found  = 1'b0;
      winner = ptr_q;
      idx    = 0;
      for (int i = 1; i <= NUM_REQUESTERS; i++) begin
         idx = (int'(ptr_q) + i) % NUM_REQUESTERS;
         if (!found && bus.req_axiiv[idx]) begin
            found  = 1'b1;
            winner = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      uv_d    = 1'b0;
      ud_d    = ud_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (found) begin
               grant_d = NUM_REQUESTERS'(1) << winner;
               ptr_d   = winner;
               busy_d  = 1'b1;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (accept) begin
               uv_d  = 1'b1;
               ud_d  = byte_g;
               cnt_d = '0;
               if (last_g) begin
                  grant_d = '0;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end else if (cnt_q >= CW'(TIMEOUT_CYCLES - 2)) begin
               // Counter would reach TIMEOUT_CYCLES-1 this cycle: force the release.
               grant_d = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_axiready = ready;
   assign bus.grant        = grant_q;
   assign bus.busy         = busy_q;
   assign bus.uart_axiiv   = uv_q;
   assign bus.uart_axiid   = ud_q;
   assign state_o          = (state_q == LOCKED);
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single `uart` transmitter between several byte-stream requesters. Typical requesters are the capture-buffer dump path and the match-score reporter. A requester locks the UART for a whole packet, which is terminated by a last-byte flag or an idle timeout. The block sits between the requester FSMs and the `uart` instance and converts each requester's valid/ready stream into the UART's single-cycle `axiiv` pulse protocol.

Parameters:
NUM_REQUESTERS, 2, number of requester ports (≥2)
DATA_WIDTH, 8, byte width; must match the uart axiid width
TIMEOUT_CYCLES, 100000, idle cycles with the grant held before a forced release (≥2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
req_axiiv  input  NUM_REQUESTERS  per-requester byte valid
req_axiid  input  NUM_REQUESTERS*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_axilast  input  NUM_REQUESTERS  marks the final byte of a packet; sampled with req_axiiv
req_axiready  output  NUM_REQUESTERS  per-requester accept
grant  output  NUM_REQUESTERS  one-hot current owner, all-zero when idle
uart_axiiv  output  1  single-cycle send pulse to uart
uart_axiid  output  DATA_WIDTH  byte to uart
uart_axiready  input  1  uart can accept a byte
busy  output  1  high while any grant is held

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - grant=0, uart_axiiv=0, uart_axiid=0, busy=0.
  - Internal last-owner pointer = NUM_REQUESTERS-1, so requester 0 has first priority.
  - Timeout counter = 0, state = IDLE.
- Reset asserted mid-packet: outputs clear immediately. A uart_axiiv pulse in flight is aborted; the byte is lost.
- States: IDLE, LOCKED.
- IDLE:
  - Scan req_axiiv starting at (pointer+1) mod N and wrapping; the first asserted index wins.
  - Registered: grant <= onehot(winner), pointer <= winner, busy <= 1, state <= LOCKED.
  - If no requester is valid, stay in IDLE.
  - req_axiready = 0 for all requesters in IDLE.
- LOCKED, ready rule:
  - req_axiready[g] = uart_axiready & ~uart_axiiv (combinational), where g is the granted index. All other readies = 0.
  - The ~uart_axiiv term enforces at least one cycle between pulses, because uart_axiready may lag one cycle after an accept.
- LOCKED, byte accept:
  - Accept occurs when req_axiiv[g] & req_axiready[g].
  - On accept: uart_axiiv <= 1 and uart_axiid <= that requester's byte. uart_axiiv is high for exactly one cycle and drops the next cycle regardless.
  - Latency: a byte accepted at cycle k appears on uart_axiiv/uart_axiid at cycle k+1.
  - On accept, the timeout counter resets to 0.
- LOCKED, release:
  - If req_axilast[g] is high on the accept, the registered outputs become grant=0, busy=0, state=IDLE.
  - Re-arbitration starts in IDLE the following cycle, so there is always ≥1 cycle between the release and the next grant.
- LOCKED, timeout:
  - Each cycle without an accept, the counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1, release as for last: grant=0, busy=0, counter=0, state=IDLE.
  - The counter saturates and never wraps.
- Fairness:
  - After a release, the just-served index has the lowest priority.
  - With all requesters continuously valid, grants rotate 0,1,…,N-1,0.
- Simultaneous events:
  - Accept and timeout in the same cycle: the accept wins and the counter resets. A release happens only if last is set.
  - req_axiiv from non-granted ports is ignored and never lost; those requesters hold until they are granted.
  - A requester deasserting valid before it is granted is legal.
- uart_axiid holds its last value when uart_axiiv is low.

Test Plan:
- Reset, then requester 0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, uart_axiready=1 → three uart_axiiv pulses at least 2 cycles apart carrying 0x41,0x42,0x43; grant returns to 0 one cycle after the last accept.
- Both requesters valid from reset, each sending 1-byte packets continuously → grants alternate 0,1,0,1; uart_axiid sequence alternates between the two data sources; neither port starves.
- Requester 1 granted; uart_axiready held low for 50 cycles → req_axiready[1]=0 and no uart_axiiv; uart_axiready rises → one pulse on the next cycle with the held byte.
- TIMEOUT_CYCLES=10: requester 0 granted, sends 1 byte without last, then goes silent while requester 1 is valid → grant drops 10 cycles after the last accept, and requester 1 is granted the cycle after.
- rst asserted asynchronously in the cycle uart_axiiv=1 → uart_axiiv, grant and busy read 0 before the next clk edge; after release, requester 0 has priority over simultaneous requesters 0 and 1.
